sync_ram_ctrl: RTL and testbench
================================

SYNC_RAM_CTRL -- requirements
Module: sync_ram_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, address width in bits.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 256, number of words, 1..2**ADDR_WIDTH.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, 1, request present.
REQ-007 The block SHALL have port req_ready, output, 1, request accepted this cycle if req_valid.
REQ-008 The block SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, ADDR_WIDTH, word address.
REQ-010 The block SHALL have port req_wdata, input, DATA_WIDTH, write data.
REQ-011 The block SHALL have port clr_start, input, 1, request a full-memory clear.
REQ-012 The block SHALL have port rsp_valid, output, 1, read data valid (one-cycle pulse per read).
REQ-013 The block SHALL have port rsp_rdata, output, DATA_WIDTH, read data.
REQ-014 The block SHALL have port rsp_err, output, 1, qualifies rsp_valid: read address out of range.
REQ-015 The block SHALL have port oor_err, output, 1, sticky: any out-of-range access accepted.
REQ-016 The block SHALL have port init_done, output, 1, high while the block is in READY.

Function
REQ-017 The block SHALL implement an FSM with states CLEAR and READY.
REQ-018 In CLEAR, the block SHALL write 0 to one address per cycle, in order 0..MEM_DEPTH-1, then enter READY; CLEAR lasts exactly MEM_DEPTH cycles.
REQ-019 The block SHALL drive req_ready = init_done = (state == READY).
REQ-020 A request SHALL be accepted only when req_valid and req_ready are both 1.
REQ-021 clr_start=1 in READY SHALL move to CLEAR next cycle, restart the clear counter at 0, and clear oor_err; any request accepted in that same cycle SHALL still complete.
REQ-022 clr_start in CLEAR SHALL be ignored.
REQ-023 An accepted write with req_addr < MEM_DEPTH SHALL update mem[req_addr] at that edge; writes produce no response.
REQ-024 An accepted read SHALL produce rsp_valid=1 with rsp_rdata=mem[req_addr] exactly 1 cycle later (base latency L=1).
REQ-025 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-026 Back-to-back reads, one per cycle, SHALL be supported with one response per cycle in order.
REQ-027 An accepted access with req_addr >= MEM_DEPTH SHALL not modify memory and SHALL set oor_err; such a read SHALL respond with rsp_rdata=0 and rsp_err=1.
REQ-028 rsp_err SHALL be 0 whenever rsp_valid is 0.
REQ-029 rsp_rdata SHALL hold its last value when rsp_valid is 0.

Reset
REQ-030 Asserting rst SHALL immediately force state=CLEAR, clear counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, oor_err=0, req_ready=0, init_done=0.
REQ-031 Asserting rst mid-clear or mid-read SHALL abort the operation; no pending response SHALL be emitted after reset.
REQ-032 After rst deasserts, a full MEM_DEPTH-cycle clear SHALL run before req_ready rises.

Configuration
REQ-033 With macro SYNC_RAM_CTRL_OUTREG_EN defined, the block SHALL add one output register stage, making read latency 2 cycles for rsp_valid, rsp_rdata and rsp_err, with throughput still one read per cycle.
REQ-034 With SYNC_RAM_CTRL_OUTREG_EN undefined, read latency SHALL be 1 cycle.
REQ-035 In both builds, the pipeline stages SHALL be reset per REQ-030, and the clear-in-flight rule of REQ-021 SHALL hold.

Verification
REQ-036 The bench SHALL cover reset then clear: with MEM_DEPTH=256, release rst -> req_ready=0 for exactly 256 cycles, then 1; a read of addr 0x37 then returns 0x00.
REQ-037 The bench SHALL cover write then read: write 0xA5 to 0x10, then read 0x10 on the next cycle -> rsp_valid one cycle later (two cycles with OUTREG) with rsp_rdata=0xA5 and rsp_err=0.
REQ-038 The bench SHALL cover back-to-back reads: read 0x01, 0x02, 0x03 on consecutive cycles holding 0x11, 0x22, 0x33 -> three consecutive rsp_valid pulses carrying 0x11, 0x22, 0x33.
REQ-039 The bench SHALL cover out of range: with MEM_DEPTH=200, write 0xFF to 0xC8 and then read 0xC8 -> memory unchanged, rsp_rdata=0x00, rsp_err=1, oor_err=1 until clr_start.
REQ-040 The bench SHALL cover software clear: write 0x5A to 0x05, pulse clr_start -> req_ready low for MEM_DEPTH cycles, then a read of 0x05 returns 0x00 and oor_err=0.
REQ-041 The bench SHALL cover reset mid-clear: assert rst at cycle 100 of a clear -> outputs zero immediately, and a full clear is restarted after release.

Source files
------------

// File: rtl/sync_ram_ctrl.sv
// -----------------------------------------------------------------------------
// sync_ram_ctrl
//
// Single-port synchronous RAM with a request/response front end and a
// self-clearing initialisation sequencer. After reset, or on clr_start, every
// word is written to zero, one address per cycle. Requests are accepted only
// once the clear has finished.
//
// Build option:
//   SYNC_RAM_CTRL_OUTREG_EN  defined   -> extra output register, read latency 2
//                            undefined -> read latency 1 (default)
//
// Parameters:
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  address width in bits
//   MEM_DEPTH   number of words, 1..2**ADDR_WIDTH
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   req_valid  request present
//   req_ready  request accepted this cycle if req_valid (high only in READY)
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   clr_start  start a full-memory clear (ignored while already clearing)
//   rsp_valid  one-cycle pulse per accepted read
//   rsp_rdata  read data, holds its value between responses
//   rsp_err    qualifies rsp_valid: read address was out of range
//   oor_err    sticky flag: an out-of-range access was accepted
//   init_done  high while in READY
//
// FSM states:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | zeroing memory, one word per cycle; requests not accepted
//   ST_READY | normal operation; requests accepted
// -----------------------------------------------------------------------------
module sync_ram_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic                  clr_start,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  oor_err,
   output logic                  init_done
);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
   // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   logic [0:0]            state_q,     state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q,   clr_cnt_d;
   logic                  oor_q,       oor_d;
   logic                  rd_valid_q,  rd_valid_d;
   logic                  rd_err_q,    rd_err_d;
   logic [DATA_WIDTH-1:0] rd_rdata_q,  rd_rdata_d;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  is_ready;
   logic                  req_fire;
   logic                  rd_fire;
   logic                  wr_fire;
   logic                  addr_in_range;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   assign is_ready      = (state_q == ST_READY);
   assign req_fire      = req_valid & is_ready;
   assign rd_fire       = req_fire & ~req_we;
   assign wr_fire       = req_fire &  req_we;
   assign addr_in_range = ({1'b0, req_addr} < DEPTH_EXT);

   // -------------------------------------------------------------------------
   // Sequencer: CLEAR walks the address counter 0..MEM_DEPTH-1, then READY.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == LAST_ADDR) begin
               state_d   = ST_READY;
               clr_cnt_d = '0;
            end
         end
         ST_READY: begin
            if (clr_start) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Memory write port: the clear sequencer owns it while clearing, otherwise
   // in-range accepted writes use it. The two never coincide because no
   // request is accepted during CLEAR.
   // -------------------------------------------------------------------------
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = req_addr;
      mem_wdata = req_wdata;
      if (state_q == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt_q;
         mem_wdata = '0;
      end else if (wr_fire && addr_in_range) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // -------------------------------------------------------------------------
   // Sticky out-of-range flag. A clear started in the same cycle as an
   // out-of-range access wins, so the flag always reads 0 after a clear.
   // -------------------------------------------------------------------------
   always_comb begin
      oor_d = oor_q;
      if (req_fire && !addr_in_range) begin
         oor_d = 1'b1;
      end
      if (is_ready && clr_start) begin
         oor_d = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Read stage. The read uses the memory contents before this edge; a write
   // in the previous cycle has already landed, so read-after-write returns the
   // new data. Read data only updates on an accepted read so it holds between
   // responses.
   // -------------------------------------------------------------------------
   always_comb begin
      rd_valid_d = rd_fire;
      rd_err_d   = rd_fire & ~addr_in_range;
      rd_rdata_d = rd_rdata_q;
      if (rd_fire) begin
         rd_rdata_d = addr_in_range ? mem[req_addr] : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         clr_cnt_q  <= '0;
         oor_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         oor_q      <= oor_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
         rd_rdata_q <= rd_rdata_d;
      end
   end

`ifdef SYNC_RAM_CTRL_OUTREG_EN
   // -------------------------------------------------------------------------
   // Output register stage: one extra cycle of latency, still one read per
   // cycle. Data holds between responses like the read stage.
   // -------------------------------------------------------------------------
   logic                  out_valid_q, out_valid_d;
   logic                  out_err_q,   out_err_d;
   logic [DATA_WIDTH-1:0] out_rdata_q, out_rdata_d;

   always_comb begin
      out_valid_d = rd_valid_q;
      out_err_d   = rd_err_q;
      out_rdata_d = rd_valid_q ? rd_rdata_q : out_rdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
         out_rdata_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_err_q   <= out_err_d;
         out_rdata_q <= out_rdata_d;
      end
   end

   assign rsp_valid = out_valid_q;
   assign rsp_err   = out_err_q;
   assign rsp_rdata = out_rdata_q;
`else
   assign rsp_valid = rd_valid_q;
   assign rsp_err   = rd_err_q;
   assign rsp_rdata = rd_rdata_q;
`endif

   assign req_ready = is_ready;
   assign init_done = is_ready;
   assign oor_err   = oor_q;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_ram_ctrl
//
// Two instances share one stimulus stream: u_dut0 with MEM_DEPTH=256 and
// u_dut1 with MEM_DEPTH=200, so the same address can be in range on one and
// out of range on the other. A behavioural model (word arrays, a countdown of
// remaining clear cycles and a latency pipe) predicts every output of both
// instances after every clock edge.
// -----------------------------------------------------------------------------
module tb_sync_ram_ctrl;

   localparam int DW   = 8;
   localparam int AW   = 8;
   localparam int DEP0 = 256;
   localparam int DEP1 = 200;
`ifdef SYNC_RAM_CTRL_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_we    = 1'b0;
   logic [AW-1:0] req_addr  = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          clr_start = 1'b0;

   logic [1:0]         o_ready;
   logic [1:0]         o_valid;
   logic [1:0]         o_err;
   logic [1:0]         o_oor;
   logic [1:0]         o_done;
   logic [1:0][DW-1:0] o_rdata;

   sync_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEP0)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_ready[0]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .clr_start(clr_start), .rsp_valid(o_valid[0]), .rsp_rdata(o_rdata[0]),
      .rsp_err(o_err[0]), .oor_err(o_oor[0]), .init_done(o_done[0])
   );

   sync_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEP1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_ready[1]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .clr_start(clr_start), .rsp_valid(o_valid[1]), .rsp_rdata(o_rdata[1]),
      .rsp_err(o_err[1]), .oor_err(o_oor[1]), .init_done(o_done[1])
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int            dep [2] = '{DEP0, DEP1};
   logic [DW-1:0] m_mem [2][256];
   bit            m_ready [2];
   int            m_left [2];
   bit            m_oor [2];
   bit            m_s1v [2];
   bit            m_s1e [2];
   logic [DW-1:0] m_s1d [2];
   bit            m_v [2];
   bit            m_e [2];
   logic [DW-1:0] m_d [2];

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ready[k] = 1'b0;
         m_left[k]  = dep[k];
         m_oor[k]   = 1'b0;
         m_s1v[k]   = 1'b0;
         m_s1e[k]   = 1'b0;
         m_s1d[k]   = '0;
         m_v[k]     = 1'b0;
         m_e[k]     = 1'b0;
         m_d[k]     = '0;
         for (int i = 0; i < 256; i++) m_mem[k][i] = '0;
      end
   endtask

   // Advance the model by one rising edge using the inputs currently driven.
   task automatic model_edge();
      bit            nv, ne, inr;
      logic [DW-1:0] nd;
      if (rst) return;
      for (int k = 0; k < 2; k++) begin
         nv = 1'b0; ne = 1'b0; nd = '0;
         if (m_ready[k]) begin
            if (req_valid) begin
               inr = (int'(req_addr) < dep[k]);
               if (!inr) m_oor[k] = 1'b1;
               if (req_we) begin
                  if (inr) m_mem[k][req_addr] = req_wdata;
               end else begin
                  nv = 1'b1;
                  ne = !inr;
                  nd = inr ? m_mem[k][req_addr] : '0;
               end
            end
            if (clr_start) begin
               m_ready[k] = 1'b0;
               m_left[k]  = dep[k];
               m_oor[k]   = 1'b0;
               for (int i = 0; i < 256; i++) m_mem[k][i] = '0;
            end
         end else begin
            m_left[k]--;
            if (m_left[k] == 0) m_ready[k] = 1'b1;
         end
         if (LAT == 2) begin
            m_v[k] = m_s1v[k];
            m_e[k] = m_s1e[k];
            if (m_s1v[k]) m_d[k] = m_s1d[k];
            m_s1v[k] = nv;
            m_s1e[k] = ne;
            if (nv) m_s1d[k] = nd;
         end else begin
            m_v[k] = nv;
            m_e[k] = ne;
            if (nv) m_d[k] = nd;
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("dut%0d req_ready", k), 32'(o_ready[k]), 32'(m_ready[k]));
         chk($sformatf("dut%0d init_done", k), 32'(o_done[k]),  32'(m_ready[k]));
         chk($sformatf("dut%0d rsp_valid", k), 32'(o_valid[k]), 32'(m_v[k]));
         chk($sformatf("dut%0d rsp_err", k),   32'(o_err[k]),   32'(m_e[k]));
         chk($sformatf("dut%0d oor_err", k),   32'(o_oor[k]),   32'(m_oor[k]));
         chk($sformatf("dut%0d rsp_rdata", k), 32'(o_rdata[k]), 32'(m_d[k]));
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit v, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit clr);
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      clr_start = clr;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      drive(1'b1, 1'b1, a, d, 1'b0);
      step();
      idle();
   endtask

   task automatic rd_chk(input string tag, input logic [AW-1:0] a,
                         input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input bit err0, input bit err1);
      drive(1'b1, 1'b0, a, '0, 1'b0);
      step();
      idle();
      repeat (LAT - 1) step();
      chk({tag, " dut0 valid"}, 32'(o_valid[0]), 32'd1);
      chk({tag, " dut0 rdata"}, 32'(o_rdata[0]), 32'(e0));
      chk({tag, " dut0 err"},   32'(o_err[0]),   32'(err0));
      chk({tag, " dut1 valid"}, 32'(o_valid[1]), 32'd1);
      chk({tag, " dut1 rdata"}, 32'(o_rdata[1]), 32'(e1));
      chk({tag, " dut1 err"},   32'(o_err[1]),   32'(err1));
   endtask

   // Counts further edges until each instance raises req_ready; 'already' is
   // the number of clear cycles spent before this task was entered.
   task automatic wait_clear(input string tag, input int already);
      int n0 = -1;
      int n1 = -1;
      idle();
      for (int c = 1; c <= 300; c++) begin
         step();
         if (n0 < 0 && o_ready[0]) n0 = c + already;
         if (n1 < 0 && o_ready[1]) n1 = c + already;
         if (n0 >= 0 && n1 >= 0) break;
      end
      chk({tag, " dut0 clear cycles"}, 32'(n0), 32'(DEP0));
      chk({tag, " dut1 clear cycles"}, 32'(n1), 32'(DEP1));
   endtask

   task automatic reset_now();
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst dut%0d ready", k), 32'(o_ready[k]), 32'd0);
         chk($sformatf("rst dut%0d valid", k), 32'(o_valid[k]), 32'd0);
         chk($sformatf("rst dut%0d rdata", k), 32'(o_rdata[k]), 32'd0);
         chk($sformatf("rst dut%0d oor", k),   32'(o_oor[k]),   32'd0);
      end
   endtask

   logic [DW-1:0] bb_exp [3] = '{8'h11, 8'h22, 8'h33};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-on reset, then the full clear.
      #2;
      reset_now();
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("post-release ready", 32'(o_ready), 32'd0);
      wait_clear("power-on", 0);
      rd_chk("cleared 0x37", 8'h37, 8'h00, 8'h00, 1'b0, 1'b0);

      // Write then read on the next cycle.
      wr(8'h10, 8'hA5);
      rd_chk("raw 0x10", 8'h10, 8'hA5, 8'hA5, 1'b0, 1'b0);

      // Back-to-back reads.
      wr(8'h01, 8'h11);
      wr(8'h02, 8'h22);
      wr(8'h03, 8'h33);
      for (int i = 0; i < 3 + LAT - 1; i++) begin
         if (i < 3) drive(1'b1, 1'b0, AW'(i + 1), '0, 1'b0);
         else       idle();
         step();
         if (i - (LAT - 1) >= 0) begin
            chk($sformatf("b2b %0d valid", i - (LAT - 1)), 32'(o_valid), 32'h3);
            chk($sformatf("b2b %0d rdata0", i - (LAT - 1)), 32'(o_rdata[0]), 32'(bb_exp[i - (LAT - 1)]));
            chk($sformatf("b2b %0d rdata1", i - (LAT - 1)), 32'(o_rdata[1]), 32'(bb_exp[i - (LAT - 1)]));
         end
      end
      idle();
      step();
      chk("b2b trailing valid", 32'(o_valid), 32'h0);

      // Out of range on the 200-word instance only.
      wr(8'hC8, 8'hFF);
      chk("oor write dut0", 32'(o_oor[0]), 32'd0);
      chk("oor write dut1", 32'(o_oor[1]), 32'd1);
      rd_chk("oor read 0xC8", 8'hC8, 8'hFF, 8'h00, 1'b0, 1'b1);
      rd_chk("intact 0xC7", 8'hC7, 8'h00, 8'h00, 1'b0, 1'b0);
      rd_chk("intact 0x10", 8'h10, 8'hA5, 8'hA5, 1'b0, 1'b0);
      repeat (3) step();
      chk("oor sticky dut1", 32'(o_oor[1]), 32'd1);

      // Software clear with a read accepted in the same cycle, clr_start
      // then held high during the clear (ignored).
      wr(8'h05, 8'h5A);
      drive(1'b1, 1'b0, 8'h10, '0, 1'b1);
      step();
      chk("clr ready low", 32'(o_ready), 32'h0);
      chk("clr oor cleared", 32'(o_oor), 32'h0);
      idle();
      repeat (LAT - 1) step();
      chk("in-flight valid", 32'(o_valid), 32'h3);
      chk("in-flight rdata0", 32'(o_rdata[0]), 32'hA5);
      chk("in-flight rdata1", 32'(o_rdata[1]), 32'hA5);
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      repeat (10) step();
      wait_clear("sw clear", LAT - 1 + 10);
      rd_chk("cleared 0x05", 8'h05, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("sw clear oor", 32'(o_oor), 32'h0);

      // Reset while a read is in flight: no response afterwards.
      wr(8'h40, 8'h33);
      drive(1'b1, 1'b0, 8'h40, '0, 1'b0);
      step();
      idle();
      reset_now();
      step();
      rst = 1'b0;
      wait_clear("mid-read reset", 0);

      // Reset at cycle 100 of a clear.
      wr(8'h40, 8'h33);
      wr(8'hD0, 8'h77);
      rd_chk("pre-clear 0x40", 8'h40, 8'h33, 8'h33, 1'b0, 1'b0);
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      step();
      idle();
      repeat (99) step();
      chk("mid-clear ready", 32'(o_ready), 32'h0);
      reset_now();
      step();
      rst = 1'b0;
      wait_clear("mid-clear reset", 0);
      rd_chk("after reset 0x40", 8'h40, 8'h00, 8'h00, 1'b0, 1'b0);

      // Randomized traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         logic [AW-1:0] a;
         bit            clr;
         clr = ($urandom_range(0, 299) == 0);
         if (clr)                          a = AW'($urandom_range(0, DEP1 - 1));
         else if ($urandom_range(0, 1) == 0) a = AW'($urandom_range(0, 15));
         else                              a = AW'($urandom_range(0, 255));
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
               DW'($urandom_range(0, 255)), clr);
         step();
      end
      idle();
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
